stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Single-clock, first-word-fall-through (FWFT) stream FIFO.
- It is the responder end of the rd_en/empty and wr_en/full handshake used by every datapath block in the FM radio chain (multiply, demodulate, filters).
- A consumer samples dout in the same cycle it sees empty==0 and asserts rd_en. A producer asserts wr_en with din whenever full==0.
- Sticky overflow/underflow flags report protocol violations to the bench.

Parameters:
- DATA_SIZE, 32, word width in bits.
- FIFO_DEPTH, 16, number of entries; power of two, >= 2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write request from producer
- din  input  DATA_SIZE  write data, sampled when wr_en && !full
- full  output  1  FIFO holds FIFO_DEPTH words
- rd_en  input  1  read/pop request from consumer
- dout  output  DATA_SIZE  head word, valid whenever empty==0 (FWFT)
- empty  output  1  FIFO holds zero words
- count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
- overflow  output  1  sticky: wr_en asserted while full
- underflow  output  1  sticky: rd_en asserted while empty

Behaviour:
- Reset:
  - Clock is the only clock; reset is asynchronous and active-high.
  - On reset assertion, immediately: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0, dout=0.
  - Storage contents are not cleared but are unreachable.
  - Reset mid-stream discards all held words. The first write after reset deassertion is the first word read.
- State:
  - Registers are wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo FIFO_DEPTH), count (ADDR_WIDTH+1 bits), and the storage array.
- Flags:
  - full, empty and count are registered values (or pure decodes of registered count).
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - None depend combinationally on wr_en or rd_en.
- Write:
  - When wr_en && !full at a rising edge: mem[wr_ptr]<=din and wr_ptr<=wr_ptr+1.
  - wr_en while full: write dropped, storage and pointers unchanged, overflow<=1.
- Read:
  - dout = mem[rd_ptr], driven combinationally while empty==0; dout=0 while empty==1.
  - When rd_en && !empty at a rising edge: rd_ptr<=rd_ptr+1.
  - rd_en while empty: no pointer change, underflow<=1.
- Count update per edge:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous events:
  - Empty, wr_en && rd_en: write accepted, read rejected, underflow set. The word appears on dout one cycle later; there is no same-cycle fall-through of din.
  - Full, wr_en && rd_en: read accepted, write rejected, overflow set. full deasserts next cycle.
  - Otherwise both are accepted; count is unchanged and pointers advance together.
- Latency:
  - Write to visible on dout with empty==0: 1 cycle.
  - Read to next word on dout: 1 cycle.
- Throughput: one write and one read per cycle sustained.
- Wrap-around: pointers roll from FIFO_DEPTH-1 to 0 with no bubble. Ordering is preserved across the wrap.
- Sticky flags: overflow and underflow are cleared only by reset.

Test Plan:
- Reset, then check: empty=1, full=0, count=0, dout=0, overflow=0, underflow=0. Assert reset asynchronously mid-cycle with 3 words held -> flags return to reset values before the next edge.
- FIFO_DEPTH=4; write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4 and full=1 after the 4th edge. A 5th write of 0x55 -> overflow=1, count stays 4. Pop 4 times -> dout 0x11,0x22,0x33,0x44, then empty=1; 0x55 is never seen.
- Empty FIFO; wr_en=1 din=0xA5 with rd_en=1 in the same cycle -> underflow=1, count=1, and dout=0xA5 with empty=0 on the next cycle.
- Full FIFO (depth 4, holding 1..4); wr_en=1 din=9 and rd_en=1 together -> dout advances to 2, count=3, full=0, overflow=1, and word 9 is absent.
- Depth 4; stream 10 words (0x100..0x109) with continuous wr_en/rd_en after a 2-word prefill -> outputs in order with no gaps, count steady at 2, pointers wrap twice.
- Random producer/consumer stalls with 32-bit signed values including 0x80000000 and 0xFFFFFFFF, against a scoreboard queue -> exact order and value match, count equals the model every cycle, no sticky flags set.

Source files
------------

// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo : single-clock first-word-fall-through stream FIFO with
//               registered occupancy flags and sticky overflow/underflow.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_fifo #(
  parameter  int DATA_SIZE  = 32,
  parameter  int FIFO_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_SIZE-1:0]  din,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_SIZE-1:0]  dout,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] C_FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [DATA_SIZE-1:0]  r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Flags decode only the registered count, never the request inputs.
  assign full      = (r_count == C_FULL_COUNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  assign w_wr_acc  = wr_en && !full;
  assign w_rd_acc  = rd_en && !empty;

  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // Storage is left uncleared by reset; the pointers make stale data unreachable.
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo : scoreboard bench for stream_fifo at depth 4.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  int            m_cnt = 0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  stream_fifo #(
    .DATA_SIZE (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .din      (din),
    .full     (full),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pops the scoreboard whenever the DUT presents a word that is being consumed.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!reset && rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", dout, 32'hDEAD_BEEF);
        end else begin
          chk("pop_data", dout, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic we, input logic [DW-1:0] d, input logic re);
    logic wa, ra;
    wr_en = we;
    din   = d;
    rd_en = re;
    @(negedge clock);
    chk("count", DW'(count), DW'(m_cnt));
    chk("full", DW'(full), DW'(m_cnt == DEPTH));
    chk("empty", DW'(empty), DW'(m_cnt == 0));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("underflow", DW'(underflow), DW'(m_unf));
    if (m_cnt == 0) chk("dout_idle", dout, '0);
    else            chk("dout_head", dout, exp_q[0]);
    wa = we && (m_cnt != DEPTH);
    ra = re && (m_cnt != 0);
    if (wa) exp_q.push_back(d);
    if (we && m_cnt == DEPTH) m_ovf = 1'b1;
    if (re && m_cnt == 0)     m_unf = 1'b1;
    m_cnt = m_cnt + int'(wa) - int'(ra);
    @(posedge clock);
    #1;
  endtask

  // Called between edges; checks take effect before the next rising edge.
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_count", DW'(count), '0);
    chk("rst_empty", DW'(empty), 32'd1);
    chk("rst_full", DW'(full), '0);
    chk("rst_dout", dout, '0);
    chk("rst_ovf", DW'(overflow), '0);
    chk("rst_unf", DW'(underflow), '0);
    reset = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  logic [DW-1:0] vals [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF,
                              32'h1234_5678, 32'hFFFF_FFFE, 32'h0000_0001, 32'hA5A5_5A5A};

  initial begin
    #2;
    do_reset();
    @(posedge clock);
    #1;

    // Fill, overflow attempt, drain.
    step(1, 32'h11, 0);
    step(1, 32'h22, 0);
    step(1, 32'h33, 0);
    step(1, 32'h44, 0);
    step(1, 32'h55, 0);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Mid-stream asynchronous reset with three words held.
    do_reset();
    step(1, 32'h1, 0);
    step(1, 32'h2, 0);
    step(1, 32'h3, 0);
    #2;
    do_reset();
    step(1, 32'h77, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Simultaneous write/read on an empty FIFO.
    step(1, 32'hA5, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);

    // Simultaneous write/read on a full FIFO.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, DW'(i), 0);
    step(1, 32'h9, 1);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    step(0, 0, 0);

    // Sustained streaming across two pointer wraps.
    do_reset();
    step(1, 32'h100, 0);
    step(1, 32'h101, 0);
    for (int i = 2; i < 10; i++) step(1, 32'h100 + DW'(i), 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // Random stalls, staying within legal handshake.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic we, re;
      we = ($urandom_range(0, 2) != 0) && (m_cnt < DEPTH);
      re = ($urandom_range(0, 2) != 0) && (m_cnt > 0);
      step(we, vals[$urandom_range(0, 7)] ^ (($urandom_range(0, 3) == 0) ? DW'(i) : '0), re);
    end
    while (m_cnt > 0) step(0, 0, 1);
    step(0, 0, 0);

    chk("queue_drained", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
